pipeline_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage (F/D/E/M/W) pipelined datapath. It keeps its own shadow copy of per-stage control state (destination register, RegWrite, MemtoReg, memory access, PC-write) for E, M and W. From that state it produces:
- forwarding selects for the E-stage ALU operands;
- stall/flush enables for the pipeline registers;
- a request/ready handshake toward data memory.
A saturating stall-cycle counter is provided for performance measurement.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 40 ++++
 rtl/hazard_stage_reg.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, the PC register index and the per-stage control record.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef struct packed {
    logic       valid;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
  } stage_ctrl_t;

  // A stage that writes the PC register redirects fetch once it retires.
  function automatic logic writes_pc(input stage_ctrl_t s, input logic [3:0] pc_reg);
    return s.regwrite && (s.wa3 == pc_reg);
  endfunction

  // M-stage result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic [3:0]  src,
                                            input stage_ctrl_t m,
                                            input stage_ctrl_t w,
                                            input logic [3:0]  pc_reg);
    if (src == pc_reg)
      return FWD_RF;
    if (m.valid && m.regwrite && (src == m.wa3))
      return FWD_M;
    if (w.valid && w.regwrite && (src == w.wa3))
      return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage of control state, with hold and bubble controls.
module hazard_stage_reg
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hold,
  input  logic        i_bubble,
  input  stage_ctrl_t i_d,
  output stage_ctrl_t o_q
);

  stage_ctrl_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else if (i_hold)
      r_q <= r_q;
    else if (i_bubble)
      r_q <= '0;
    else
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding selects,
// stall/flush enables, memory wait handling and a stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter logic [3:0]  PC_REG = pipeline_hazard_ctrl_pkg::PC_REG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             BranchTakenE,
  input  logic             MemReadyM,
  output logic             MemReqM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCycles
);

  stage_ctrl_t      w_d;
  stage_ctrl_t      w_e;
  stage_ctrl_t      w_m;
  stage_ctrl_t      w_w;
  logic             w_mem_wait;
  logic             w_ldr_stall;
  logic             w_pcwr_pend;
  logic [CNT_W-1:0] r_stall_cycles;

  assign w_d = '{valid:    1'b1,
                 ra1:      RA1D,
                 ra2:      RA2D,
                 wa3:      WA3D,
                 regwrite: RegWriteD,
                 memtoreg: MemtoRegD,
                 memwrite: MemWriteD};

  assign MemReqM    = w_m.valid && (w_m.memtoreg || w_m.memwrite);
  assign w_mem_wait = MemReqM && !MemReadyM;

  assign w_ldr_stall = w_e.valid && w_e.memtoreg && w_e.regwrite &&
                       ((RA1D == w_e.wa3) || (RA2D == w_e.wa3));

  assign w_pcwr_pend = (RegWriteD && (WA3D == PC_REG)) ||
                       writes_pc(w_e, PC_REG) || writes_pc(w_m, PC_REG);

  // Memory wait freezes everything up to M and drains W; branches wait for release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = w_ldr_stall || w_pcwr_pend;
      StallD = w_ldr_stall;
      FlushD = w_pcwr_pend || writes_pc(w_w, PC_REG) || BranchTakenE;
      FlushE = w_ldr_stall || BranchTakenE;
    end
  end

  assign ForwardAE = fwd_select(w_e.ra1, w_m, w_w, PC_REG);
  assign ForwardBE = fwd_select(w_e.ra2, w_m, w_w, PC_REG);

  hazard_stage_reg u_stage_e (
    .clk      (clk),
    .rst_n    (reset),
    .i_hold   (w_mem_wait),
    .i_bubble (FlushE),
    .i_d      (w_d),
    .o_q      (w_e)
  );

  hazard_stage_reg u_stage_m (
    .clk      (clk),
    .rst_n    (reset),
    .i_hold   (w_mem_wait),
    .i_bubble (1'b0),
    .i_d      (w_e),
    .o_q      (w_m)
  );

  hazard_stage_reg u_stage_w (
    .clk      (clk),
    .rst_n    (reset),
    .i_hold   (1'b0),
    .i_bubble (w_mem_wait),
    .i_d      (w_m),
    .o_q      (w_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cycles <= '0;
    else if (StallF && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign StallCycles = r_stall_cycles;

  logic w_unused_w;
  assign w_unused_w = ^{w_w.ra1, w_w.ra2, w_w.memtoreg, w_w.memwrite};

endmodule
